axis_fifo_prog: RTL and testbench

//  Parametrised AXI-Stream FIFO. Successor to the fixed output FIFO.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/memory_dual_port.sv | 31 +++
 rtl/axis_fifo_prog.sv | 81 ++++++++
 tb/tb_axis_fifo_prog.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for the AXI-Stream FIFO family.
//   WORD_W      - default TDATA width of the stream word type
//   axis_word_t - one stored stream beat (TLAST + TDATA)
//   ptr_inc     - modulo increment, wraps DEPTH-1 -> 0 for any DEPTH
package fifo_pkg;

  localparam int WORD_W = 24;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } axis_word_t;

  // Pointers never visit DEPTH, so non-power-of-2 depths work unchanged.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/memory_dual_port.sv
// memory_dual_port: simple dual-port RAM, one write and one registered read port.
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address (sampled on clk)
//   rdata - registered read data
// A write and a read to the same address in one cycle return the new data.
module memory_dual_port #(
  parameter int WIDTH = 25,
  parameter int SIZE  = 19,
  localparam int AW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    // write-through keeps the empty->1 and single-entry-refill cases bubble-free
    if (we && (waddr == raddr)) rdata <= wdata;
    else                        rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_fifo_prog.sv
// axis_fifo_prog: AXI-Stream FIFO with TLAST, arbitrary DEPTH, occupancy and
// almost-full / almost-empty flags, synchronous flush.
//   clk, reset          - clock, synchronous active-high reset
//   IN_AXIS_*           - upstream stream (TDATA, TLAST, TVALID in; TREADY out)
//   OUT_AXIS_*          - downstream stream (TDATA, TLAST, TVALID out; TREADY in)
//   flush               - synchronous clear of contents (reset has priority)
//   count               - occupancy 0..DEPTH
//   almost_full/_empty  - count >= AFULL_THRESH / count <= AEMPTY_THRESH
module axis_fifo_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 24,
  parameter int DEPTH         = 19,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  localparam int LOGDEPTH     = $clog2(DEPTH),
  localparam int CNTW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] IN_AXIS_TDATA,
  input  logic             IN_AXIS_TLAST,
  input  logic             IN_AXIS_TVALID,
  output logic             IN_AXIS_TREADY,
  output logic [WIDTH-1:0] OUT_AXIS_TDATA,
  output logic             OUT_AXIS_TLAST,
  output logic             OUT_AXIS_TVALID,
  input  logic             OUT_AXIS_TREADY,
  input  logic             flush,
  output logic [CNTW-1:0]  count,
  output logic             almost_full,
  output logic             almost_empty
);

  logic [LOGDEPTH-1:0] wr_ptr, rd_ptr, rd_ptr_next;
  logic [CNTW-1:0]     count_q;
  logic                wr_en, rd_en, full;

  assign full            = (count_q == CNTW'(DEPTH));
  assign OUT_AXIS_TVALID = (count_q != '0);
  assign rd_en           = OUT_AXIS_TVALID & OUT_AXIS_TREADY;
  // a full FIFO still accepts when the head leaves this cycle
  assign IN_AXIS_TREADY  = !full | rd_en;
  assign wr_en           = IN_AXIS_TVALID & IN_AXIS_TREADY;

  assign count        = count_q;
  assign almost_full  = (count_q >= CNTW'(AFULL_THRESH));
  assign almost_empty = (count_q <= CNTW'(AEMPTY_THRESH));

  // registered read looks one step ahead so the head is always presented
  assign rd_ptr_next = rd_en ? LOGDEPTH'(ptr_inc(32'(rd_ptr), 32'(DEPTH))) : rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= LOGDEPTH'(ptr_inc(32'(wr_ptr), 32'(DEPTH)));
      rd_ptr <= rd_ptr_next;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  memory_dual_port #(
    .WIDTH (WIDTH + 1),
    .SIZE  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en & ~flush & ~reset),
    .waddr (wr_ptr),
    .wdata ({IN_AXIS_TLAST, IN_AXIS_TDATA}),
    .raddr (rd_ptr_next),
    .rdata ({OUT_AXIS_TLAST, OUT_AXIS_TDATA})
  );

endmodule

// File: tb/tb_axis_fifo_prog.sv
module tb_axis_fifo_prog;
  import fifo_pkg::*;

  localparam int W    = 24;
  localparam int D    = 19;
  localparam int AF   = D - 2;
  localparam int AE   = 1;
  localparam int CNTW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic [CNTW-1:0] count;
  logic          almost_full, almost_empty;

  axis_word_t exp_q[$];
  int checks = 0;
  int passed = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  axis_fifo_prog #(.WIDTH(W), .DEPTH(D)) dut (
    .clk             (clk),
    .reset           (reset),
    .IN_AXIS_TDATA   (in_data),
    .IN_AXIS_TLAST   (in_last),
    .IN_AXIS_TVALID  (in_valid),
    .IN_AXIS_TREADY  (in_ready),
    .OUT_AXIS_TDATA  (out_data),
    .OUT_AXIS_TLAST  (out_last),
    .OUT_AXIS_TVALID (out_valid),
    .OUT_AXIS_TREADY (out_ready),
    .flush           (flush),
    .count           (count),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  // One clock cycle: drive, check occupancy-derived outputs against the model, then
  // update the model with whatever the handshake rules say was accepted.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic l, input logic r,
                     input logic f = 1'b0, input logic rs = 1'b0);
    int  sz;
    bit  can_take, acc;
    reset = rs; flush = f; in_valid = v; in_data = d; in_last = l; out_ready = r;
    @(negedge clk);
    sz       = exp_q.size();
    can_take = (sz < D) || (sz > 0 && r);
    acc      = v && can_take;
    chk("count",        int'(count),        sz);
    chk("out_valid",    int'(out_valid),    int'(sz > 0));
    chk("in_ready",     int'(in_ready),     int'(can_take));
    chk("almost_full",  int'(almost_full),  int'(sz >= AF));
    chk("almost_empty", int'(almost_empty), int'(sz <= AE));
    #2;
    if (rs || f) exp_q.delete();
    else if (acc) exp_q.push_back('{last: l, data: d});
    @(posedge clk); #1;
  endtask

  // Monitor: head must match model front whenever valid; pop on output handshake.
  always @(negedge clk) begin
    #1;
    if (started && out_valid && exp_q.size() > 0) begin
      chk("head", int'({out_last, out_data}), int'({exp_q[0].last, exp_q[0].data}));
      if (out_ready && !reset && !flush) void'(exp_q.pop_front());
    end
  end

  initial begin
    logic [W-1:0] v;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;

    // 1: three writes, consumer stalled
    for (int i = 0; i < 3; i++) cyc(1'b1, W'(24'hA1 + i), 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);

    // 2: fill to DEPTH, try to overfill, then write+read when full
    for (int i = 3; i < D; i++) cyc(1'b1, W'(24'h100 + i), 1'b0, 1'b0);
    repeat (2) cyc(1'b1, 24'hDEAD, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, W'(24'h200 + i), 1'(i), 1'b1);

    // 3: streaming across pointer wrap
    for (int i = 0; i < 3 * D; i++) cyc(1'b1, W'(24'h300 + i), 1'($urandom_range(0, 1)), 1'b1);
    repeat (D + 2) cyc(1'b0, '0, 1'b0, 1'b1);

    // 4: single word through an empty FIFO
    cyc(1'b1, 24'h55, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b1);

    // 5: flush at count=7 with a concurrent write
    for (int i = 0; i < 7; i++) cyc(1'b1, W'(24'h500 + i), 1'b0, 1'b0);
    cyc(1'b1, 24'hBAD, 1'b0, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b1);

    // 6: reset mid-stream at count=10
    for (int i = 0; i < 10; i++) cyc(1'b1, W'(24'h600 + i), 1'b0, 1'b0);
    cyc(1'b1, 24'hBAD, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 24'h00BEEF, 1'b1, 1'b1);
    repeat (2) cyc(1'b0, '0, 1'b0, 1'b1);

    // random traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      v = W'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), v, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, (i / 500) % 3 + 1) != 0),
          1'($urandom_range(0, 127) == 0), 1'($urandom_range(0, 255) == 0));
    end
    repeat (D + 2) cyc(1'b0, '0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
